// File: rtl/avg_pkg.sv
// Shared definitions for the 3x3 average front end: state encoding,
// default core latency and the width helper used by every block.
package avg_pkg;

    localparam int unsigned CORE_LAT_DEFAULT = 5;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFill  = 2'd1,
        StRun   = 2'd2,
        StFlush = 2'd3
    } state_e;

    // Number of bits needed to hold 'value' (at least 1).
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned bits;
        v    = value;
        bits = 0;
        while (v > 0) begin
            bits++;
            v = v >> 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/avg_line_buf.sv
// Two chained row delays sharing one address: each access returns the
// pixels one and two rows above, then shifts the new pixel in.
module avg_line_buf
    import avg_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = 14,
    parameter int unsigned DEPTH       = 128,
    localparam int unsigned AW         = clogb2(DEPTH - 1)
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   en,
    input  logic [AW-1:0]          addr,
    input  logic [PIXEL_WIDTH-1:0] wdata,
    output logic [PIXEL_WIDTH-1:0] rd0,
    output logic [PIXEL_WIDTH-1:0] rd1
);

    logic [PIXEL_WIDTH-1:0] mem0 [DEPTH];
    logic [PIXEL_WIDTH-1:0] mem1 [DEPTH];

    // RAM write: row r-1 moves down to the r-2 buffer as row r lands in the r-1 buffer.
    always_ff @(posedge clk) begin
        if (en) begin
            mem0[addr] <= wdata;
            mem1[addr] <= mem0[addr];
        end
    end

    // Read register sees the old contents (read-before-write); reset so outputs start at 0.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rd0 <= '0;
            rd1 <= '0;
        end else if (en) begin
            rd0 <= mem0[addr];
            rd1 <= mem1[addr];
        end
    end

endmodule

// File: rtl/avg3x3_stream_ctrl.sv
// Raster-stream sequencer for the 3x3 average core: frame FSM, position
// counters, framing checks, line buffering and the sideband delay line.
module avg3x3_stream_ctrl
    import avg_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH  = 14,
    parameter int unsigned IMAGE_WIDTH  = 128,
    parameter int unsigned IMAGE_HEIGHT = 128,
    parameter int unsigned CORE_LAT     = CORE_LAT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     arstn,
    input  logic                     enable,
    input  logic [PIXEL_WIDTH-1:0]   s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     s_sof,
    input  logic                     s_eol,
    output logic [3*PIXEL_WIDTH-1:0] core_data,
    output logic                     core_valid,
    output logic                     m_sof,
    output logic                     m_eol,
    output logic                     m_eof,
    output logic                     busy,
    output logic                     err_sof,
    output logic                     err_eol
);

    localparam int unsigned COL_W = clogb2(IMAGE_WIDTH - 1);
    localparam int unsigned ROW_W = clogb2(IMAGE_HEIGHT - 1);
    localparam int unsigned FL_W  = clogb2(CORE_LAT - 1);

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_FILL_LAST = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_RUN0      = ROW_W'(2);
    localparam logic [FL_W-1:0]  FL_LAST       = FL_W'(CORE_LAT - 1);

    state_e               state_q, state_d, st_base;
    logic [COL_W-1:0]     col_q, col_d, col_eff;
    logic [ROW_W-1:0]     row_q, row_d, row_base;
    logic [FL_W-1:0]      flush_q, flush_d;

    logic                 accept;
    logic                 frame_beat;
    logic                 start;
    logic                 abort;
    logic                 row_end;
    logic                 beat;
    logic [2:0]           beat_sb;
    logic                 err_sof_d, err_eol_d;
    logic                 sr_clr;

    logic [PIXEL_WIDTH-1:0] data_q;
    logic [PIXEL_WIDTH-1:0] lb_rd0, lb_rd1;
    logic                   core_valid_q;
    logic [2:0]             sb_q;
    logic [2:0]             sr_q [CORE_LAT];
    logic                   err_sof_q, err_eol_q;

    assign accept = s_valid & s_ready;

    // Next state, counters and framing checks for the current beat.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        flush_d    = flush_q;
        frame_beat = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        col_eff    = col_q;
        row_base   = row_q;
        st_base    = state_q;
        beat       = 1'b0;
        beat_sb    = 3'b000;
        err_sof_d  = 1'b0;
        err_eol_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept && s_sof && enable) begin
                    frame_beat = 1'b1;
                    start      = 1'b1;
                end
            end
            StFill, StRun: begin
                if (accept) begin
                    frame_beat = 1'b1;
                    if (s_sof) begin
                        err_sof_d = 1'b1;
                        // A stray sof restarts the frame unless we are winding down.
                        if (enable) start = 1'b1;
                        else        abort = 1'b1;
                    end
                end
            end
            StFlush: begin
                if (flush_q == FL_LAST) begin
                    state_d = StIdle;
                    flush_d = '0;
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A frame-start beat always sits at row 0, column 0.
        if (start) begin
            col_eff  = '0;
            row_base = '0;
            st_base  = StFill;
        end
        row_end = (col_eff == COL_LAST);

        if (frame_beat && !abort) begin
            if (s_eol != row_end) begin
                err_eol_d = 1'b1;
                abort     = 1'b1;
            end else begin
                state_d = st_base;
                row_d   = row_base;
                col_d   = row_end ? '0 : col_eff + 1'b1;
                if (st_base == StRun) begin
                    beat    = 1'b1;
                    beat_sb = {(row_base == ROW_RUN0) && (col_eff == '0), row_end,
                               row_end && (row_base == ROW_LAST)};
                end
                if (row_end) begin
                    row_d = row_base + 1'b1;
                    if (st_base == StFill && row_base == ROW_FILL_LAST) begin
                        state_d = StRun;
                    end
                    if (st_base == StRun && row_base == ROW_LAST) begin
                        state_d = StFlush;
                        flush_d = '0;
                        row_d   = '0;
                    end
                end
            end
        end

        if (abort) begin
            state_d = StIdle;
            col_d   = '0;
            row_d   = '0;
        end
    end

    // Sideband in flight belongs to the frame being dropped or restarted.
    assign sr_clr = frame_beat && (state_q != StIdle) && (abort || start);

    // FSM state and position counters.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            flush_q <= flush_d;
        end
    end

    // Output registers: current pixel, core beat strobe, its sideband and error pulses.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            data_q       <= '0;
            core_valid_q <= 1'b0;
            sb_q         <= 3'b000;
            err_sof_q    <= 1'b0;
            err_eol_q    <= 1'b0;
        end else begin
            if (frame_beat) data_q <= s_data;
            core_valid_q <= beat;
            sb_q         <= beat_sb;
            err_sof_q    <= err_sof_d;
            err_eol_q    <= err_eol_d;
        end
    end

    // Sideband delay line: one slot per core pipeline stage, zeros on non-beat cycles.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            for (int i = 0; i < CORE_LAT; i++) sr_q[i] <= 3'b000;
        end else if (sr_clr) begin
            for (int i = 0; i < CORE_LAT; i++) sr_q[i] <= 3'b000;
        end else begin
            sr_q[0] <= core_valid_q ? sb_q : 3'b000;
            for (int i = 1; i < CORE_LAT; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    avg_line_buf #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .DEPTH       (IMAGE_WIDTH)
    ) u_line_buf (
        .clk   (clk),
        .arstn (arstn),
        .en    (frame_beat),
        .addr  (col_eff),
        .wdata (s_data),
        .rd0   (lb_rd0),
        .rd1   (lb_rd1)
    );

    assign s_ready    = (state_q != StFlush);
    assign busy       = (state_q != StIdle);
    assign core_data  = {lb_rd1, lb_rd0, data_q};
    assign core_valid = core_valid_q;
    assign m_sof      = sr_q[CORE_LAT-1][2];
    assign m_eol      = sr_q[CORE_LAT-1][1];
    assign m_eof      = sr_q[CORE_LAT-1][0];
    assign err_sof    = err_sof_q;
    assign err_eol    = err_eol_q;

endmodule

// File: tb/tb_avg3x3_stream_ctrl.sv
// Self-checking bench for avg3x3_stream_ctrl on an 8x4 image with a
// frame-level reference model (pixel positions, stored rows, scheduled sideband).
module tb_avg3x3_stream_ctrl;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int PW = 14;
    localparam int L  = 5;
    localparam int SCH = 4096;

    logic            clk = 1'b0;
    logic            arstn = 1'b0;
    logic            enable = 1'b1;
    logic [PW-1:0]   s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic            s_sof = 1'b0;
    logic            s_eol = 1'b0;
    logic [3*PW-1:0] core_data;
    logic            core_valid;
    logic            m_sof, m_eol, m_eof;
    logic            busy, err_sof, err_eol;

    int total = 0;
    int bad   = 0;

    avg3x3_stream_ctrl #(
        .PIXEL_WIDTH  (PW),
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .CORE_LAT     (L)
    ) dut (
        .clk        (clk),
        .arstn      (arstn),
        .enable     (enable),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_sof      (s_sof),
        .s_eol      (s_eol),
        .core_data  (core_data),
        .core_valid (core_valid),
        .m_sof      (m_sof),
        .m_eol      (m_eol),
        .m_eof      (m_eof),
        .busy       (busy),
        .err_sof    (err_sof),
        .err_eol    (err_eol)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            n_edge = 0;
    bit            in_frame = 1'b0;
    int            pos = 0;
    int            flush_left = 0;
    bit [PW-1:0]   img [0:H-1][0:W-1];
    bit            e_cv = 1'b0;
    bit [3*PW-1:0] e_data = '0;
    bit            e_esof = 1'b0;
    bit            e_eeol = 1'b0;
    bit [2:0]      sched [0:SCH-1];

    function automatic int ix(input int k);
        return k % SCH;
    endfunction

    // Frame model: positions counted in raster order, sideband scheduled L cycles after each beat.
    always @(posedge clk or negedge arstn) begin
        bit was, go;
        int r, c;
        if (!arstn) begin
            in_frame   = 1'b0;
            flush_left = 0;
            pos        = 0;
            e_cv       = 1'b0;
            e_esof     = 1'b0;
            e_eeol     = 1'b0;
            for (int k = 0; k <= L; k++) sched[ix(n_edge + k)] = 3'b000;
        end else begin
            n_edge++;
            e_cv   = 1'b0;
            e_esof = 1'b0;
            e_eeol = 1'b0;
            go     = 1'b0;
            was    = in_frame;
            sched[ix(n_edge + L)] = 3'b000;
            if (flush_left > 0) begin
                flush_left--;
            end else if (s_valid) begin
                if (!in_frame) begin
                    if (s_sof && enable) begin pos = 0; go = 1'b1; end
                end else if (s_sof) begin
                    e_esof = 1'b1;
                    for (int k = 0; k < L; k++) sched[ix(n_edge + k)] = 3'b000;
                    if (enable) begin pos = 0; go = 1'b1; end
                    else in_frame = 1'b0;
                end else begin
                    go = 1'b1;
                end
            end
            if (go) begin
                r = pos / W;
                c = pos % W;
                if (s_eol != (c == W - 1)) begin
                    e_eeol = 1'b1;
                    if (was) for (int k = 0; k < L; k++) sched[ix(n_edge + k)] = 3'b000;
                    in_frame = 1'b0;
                end else begin
                    in_frame  = 1'b1;
                    img[r][c] = s_data;
                    if (r >= 2) begin
                        e_cv   = 1'b1;
                        e_data = {img[r-2][c], img[r-1][c], s_data};
                        sched[ix(n_edge + L)] = {(r == 2 && c == 0), (c == W - 1),
                                                 (c == W - 1 && r == H - 1)};
                    end
                    pos++;
                    if (pos == W * H) begin
                        in_frame   = 1'b0;
                        flush_left = L;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int            n_beats = 0;
    int            n_eof = 0;
    logic [3*PW-1:0] beat_log [0:1023];

    // Compare every output against the model between clock edges.
    always @(negedge clk) begin
        check("core_valid", 64'(core_valid), 64'(e_cv));
        if (e_cv) check("core_data", 64'(core_data), 64'(e_data));
        check("m_sideband", 64'({m_sof, m_eol, m_eof}), 64'(sched[ix(n_edge)]));
        check("busy", 64'(busy), 64'(in_frame || flush_left > 0));
        check("s_ready", 64'(s_ready), 64'(flush_left == 0));
        check("err_sof", 64'(err_sof), 64'(e_esof));
        check("err_eol", 64'(err_eol), 64'(e_eeol));
        if (core_valid) begin
            beat_log[n_beats % 1024] = core_data;
            n_beats++;
        end
        if (m_eof) n_eof++;
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b0;
            s_sof   = 1'($urandom);
            s_eol   = 1'($urandom);
            s_data  = PW'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input logic [PW-1:0] d, input logic sof, input logic eol,
                              input int gap_pct);
        logic rdy;
        int   budget;
        while (int'($urandom_range(99)) < gap_pct) idle(1);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        s_eol   = eol;
        budget  = 50;
        forever begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            budget--;
            if (budget == 0) begin
                check("ready_timeout", 64'(0), 64'(1));
                break;
            end
        end
    endtask

    task automatic send_seq(input int p0, input int n, input bit sof_first, input int gap,
                            input bit rnd);
        int p;
        for (int k = 0; k < n; k++) begin
            p = p0 + k;
            drive_beat(rnd ? PW'($urandom) : PW'(p), sof_first && (k == 0), (p % W) == W - 1, gap);
        end
        idle(1);
    endtask

    localparam logic [3*PW-1:0] BEAT_R2C3 = {14'd3, 14'd11, 14'd19};

    initial begin
        int b0, e0;
        repeat (3) @(posedge clk);
        #1 arstn = 1'b1;
        idle(2);

        // 1: clean ramp frame
        b0 = n_beats; e0 = n_eof;
        send_seq(0, W * H, 1'b1, 0, 1'b0);
        idle(L + 3);
        check("s1_beats", 64'(n_beats - b0), 64'(16));
        check("s1_eof", 64'(n_eof - e0), 64'(1));
        check("s1_r2c3", 64'(beat_log[(b0 + 3) % 1024]), 64'(BEAT_R2C3));

        // 2: same frame with 50% valid gaps
        b0 = n_beats; e0 = n_eof;
        send_seq(0, W * H, 1'b1, 50, 1'b0);
        idle(L + 3);
        check("s2_beats", 64'(n_beats - b0), 64'(16));
        check("s2_eof", 64'(n_eof - e0), 64'(1));
        check("s2_r2c3", 64'(beat_log[(b0 + 3) % 1024]), 64'(BEAT_R2C3));

        // 3: early eol in row 1, then a clean frame
        b0 = n_beats;
        send_seq(0, W + 5, 1'b1, 20, 1'b1);
        drive_beat(PW'($urandom), 1'b0, 1'b1, 0);
        idle(1);
        check("s3_busy", 64'(busy), 64'(0));
        idle(4);
        check("s3_beats", 64'(n_beats - b0), 64'(0));
        b0 = n_beats;
        send_seq(0, W * H, 1'b1, 20, 1'b1);
        idle(L + 3);
        check("s3_clean_beats", 64'(n_beats - b0), 64'(16));

        // 4: stray sof at row 2 col 4 restarts the frame
        b0 = n_beats;
        send_seq(0, 2 * W + 4, 1'b1, 30, 1'b1);
        send_seq(0, W * H, 1'b1, 30, 1'b1);
        idle(L + 3);
        check("s4_beats", 64'(n_beats - b0), 64'(20));

        // 5: enable dropped mid-frame
        b0 = n_beats; e0 = n_eof;
        send_seq(0, 10, 1'b1, 30, 1'b1);
        enable = 1'b0;
        send_seq(10, W * H - 10, 1'b0, 30, 1'b1);
        idle(L + 2);
        drive_beat(PW'($urandom), 1'b1, 1'b0, 0);
        idle(3);
        check("s5_busy", 64'(busy), 64'(0));
        check("s5_beats", 64'(n_beats - b0), 64'(16));
        check("s5_eof", 64'(n_eof - e0), 64'(1));
        enable = 1'b1;

        // 6: async reset during RUN, then a clean ramp frame
        send_seq(0, 2 * W + 3, 1'b1, 0, 1'b1);
        #1 arstn = 1'b0;
        #1 check("async_rst", 64'({core_valid, core_data, m_sof, m_eol, m_eof, busy,
                                   err_sof, err_eol}), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1 arstn = 1'b1;
        idle(2);
        b0 = n_beats; e0 = n_eof;
        send_seq(0, W * H, 1'b1, 0, 1'b0);
        idle(L + 3);
        check("s6_beats", 64'(n_beats - b0), 64'(16));
        check("s6_eof", 64'(n_eof - e0), 64'(1));
        check("s6_r2c3", 64'(beat_log[(b0 + 3) % 1024]), 64'(BEAT_R2C3));

        // extra: back-to-back random frames with gaps
        for (int f = 0; f < 3; f++) send_seq(0, W * H, 1'b1, 25, 1'b1);
        idle(L + 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
